// File: rtl/reg_file_pkg.sv
// Shared register-file constants: clear-sequencer state encoding
// and the default datapath widths used by decode and ALU.
package reg_file_pkg;

   localparam logic RF_IDLE  = 1'b0;
   localparam logic RF_CLEAR = 1'b1;

   localparam int RF_DATA_W = 8;
   localparam int RF_ADDR_W = 4;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks ptr over every entry after reset or on clr,
// asserting busy and presenting one zero-write per cycle.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   logic              state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   // Next state: clr only starts a clear from IDLE; CLEAR ends after LAST.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == RF_CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == LAST) state_d = RF_IDLE;
      end else if (clr) begin
         state_d = RF_CLEAR;
         ptr_d   = '0;
      end
   end

   // State register; reset (also mid-clear) restarts the sweep at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy     = (state_q == RF_CLEAR);
   assign clr_we   = busy;
   assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_nr1w_clr.sv
// NRD-read / 1-write register file with write bypass, optional
// hard-wired zero entry and a sequenced clear with busy masking.
module reg_file_nr1w_clr
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [NRD*ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0]     wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic                  we,
   output logic [NRD*DATA_W-1:0] rd,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_k  [NRD];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   reg_file_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Write port mux: the sequencer owns the array while busy; a clear
   // request or reset in the same cycle drops the external write.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wa;
      mem_wd = wd;
      if (busy) begin
         mem_we = clr_we;
         mem_wa = clr_addr;
         mem_wd = '0;
      end else if (we && !clr && !rst &&
                   !(ZERO_REG != 0 && wa == '0)) begin
         mem_we = 1'b1;
      end
   end

   // Storage array; no reset, contents are defined by the clear sweep.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra_k;
      assign ra_k = ra[k*ADDR_W +: ADDR_W];
      assign rd_k[k] =
         busy                               ? '0 :
         (ZERO_REG != 0 && ra_k == '0)      ? '0 :
         (BYPASS != 0 && we && wa == ra_k)  ? wd :
                                              mem_q[ra_k];
   end

   // Pack the per-port results onto the flat read bus.
   always_comb begin
      rd = '0;
      for (int k = 0; k < NRD; k++) begin
         rd[k*DATA_W +: DATA_W] = rd_k[k];
      end
   end

endmodule

// File: tb/tb_reg_file_nr1w_clr.sv
// Scoreboard bench: stimulus queues expected values, a negedge
// monitor pops and compares them against both DUT configurations.
module tb_reg_file_nr1w_clr;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  wa  = '0;
   logic [7:0]  wd  = '0;
   logic [7:0]  ra  = '0;
   logic [15:0] ra2 = '0;
   logic [15:0] rd;
   logic [31:0] rd2;
   logic        busy, busy2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
   } chk_t;

   chk_t sb[$];

   reg_file_nr1w_clr dut (
      .clk (clk), .rst (rst), .clr (clr), .ra (ra), .wa (wa),
      .wd (wd), .we (we), .rd (rd), .busy (busy)
   );

   reg_file_nr1w_clr #(
      .DATA_W (8), .ADDR_W (4), .NRD (4), .BYPASS (0), .ZERO_REG (1)
   ) dut2 (
      .clk (clk), .rst (rst), .clr (clr), .ra (ra2), .wa (wa),
      .wd (wd), .we (we), .rd (rd2), .busy (busy2)
   );

   always #5 clk = ~clk;

   // sel: 0 busy, 1/2 dut rd0/rd1, 3..6 dut2 rd0..rd3, 7 dut2 busy
   function automatic logic [7:0] actual(int sel);
      case (sel)
         0:       return {7'd0, busy};
         1:       return rd[7:0];
         2:       return rd[15:8];
         7:       return {7'd0, busy2};
         default: return rd2[(sel-3)*8 +: 8];
      endcase
   endfunction

   // Monitor: outputs are stable mid-cycle, compare everything queued.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         chk_t c;
         logic [7:0] a;
         c = sb.pop_front();
         a = actual(c.sel);
         checks++;
         if (a !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     c.name, a, c.exp, $time);
         end
      end
   end

   task automatic chk(input string n, input int s, input logic [7:0] e);
      sb.push_back('{n, s, e});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] fill(int a);
      return 8'(a * 8'h11);
   endfunction

   function automatic logic [7:0] zfill(int a);
      return (a == 0) ? 8'h00 : fill(a);
   endfunction

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. reset then full clear sweep
      step();
      rst = 1'b1;
      step();
      chk("busy_in_rst", 0, 8'h01);
      step();
      rst = 1'b0;
      for (int e = 0; e < 16; e++) begin
         ra = {4'(15 - e), 4'(e)};
         chk("busy_clr", 0, 8'h01);
         chk("busy2_clr", 7, 8'h01);
         chk("rd0_clr", 1, 8'h00);
         step();
      end
      chk("busy_done", 0, 8'h00);
      chk("busy2_done", 7, 8'h00);
      for (int i = 0; i < 16; i++) begin
         ra = {4'(15 - i), 4'(i)};
         chk("zero_rd0", 1, 8'h00);
         chk("zero_rd1", 2, 8'h00);
         step();
      end

      // 2. fill and readback sweep
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; wa = 4'(i); wd = fill(i);
         step();
      end
      we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ra  = {4'(15 - i), 4'(i)};
         ra2 = {4'(i), 4'((i + 1) % 16), 4'(15 - i), 4'(i)};
         chk("fill_rd0", 1, fill(i));
         chk("fill_rd1", 2, fill(15 - i));
         chk("fill2_rd0", 3, zfill(i));
         chk("fill2_rd1", 4, zfill(15 - i));
         chk("fill2_rd2", 5, zfill((i + 1) % 16));
         chk("fill2_rd3", 6, zfill(i));
         step();
      end

      // 3. same-cycle bypass vs. no bypass
      we = 1'b1; wa = 4'd3; wd = 8'hAA;
      ra = 8'h03; ra2 = 16'h0003;
      chk("bypass_rd0", 1, 8'hAA);
      chk("nobyp_old", 3, 8'h33);
      step();
      we = 1'b0;
      chk("bypass_after", 1, 8'hAA);
      chk("nobyp_after", 3, 8'hAA);
      step();

      // 4. no-write hold and zero register
      we = 1'b0; wa = 4'd5; wd = 8'h11;
      step();
      ra = 8'h05; ra2 = 16'h0005;
      chk("hold5", 1, 8'h55);
      chk("hold5_2", 3, 8'h55);
      step();
      we = 1'b1; wa = 4'd0; wd = 8'hFF;
      ra = 8'h00; ra2 = 16'h0000;
      chk("byp_e0", 1, 8'hFF);
      chk("zreg_byp", 3, 8'h00);
      step();
      we = 1'b0;
      chk("e0_written", 1, 8'hFF);
      chk("zreg_e0", 3, 8'h00);
      step();

      // 5. clr with a colliding write; second clr and late write ignored
      clr = 1'b1; we = 1'b1; wa = 4'd7; wd = 8'h3C; ra = 8'h07;
      chk("clr_pre_busy", 0, 8'h00);
      chk("clr_pre_byp", 1, 8'h3C);
      step();
      clr = 1'b0; we = 1'b0;
      for (int e = 0; e < 16; e++) begin
         clr = (e == 7);
         we  = (e == 12);
         wa  = 4'd2; wd = 8'h77; ra = 8'h02;
         chk("busy_mid", 0, 8'h01);
         chk("rd_masked", 1, 8'h00);
         step();
      end
      clr = 1'b0; we = 1'b0;
      chk("busy_mid_done", 0, 8'h00);
      ra = 8'h07;
      step();
      chk("e7_cleared", 1, 8'h00);
      ra = 8'h02;
      step();
      chk("e2_no_write", 1, 8'h00);
      step();

      // 6. reset asserted at edge 10 of a clear
      we = 1'b1; wa = 4'd9; wd = 8'h99;
      step();
      we = 1'b0; ra = 8'h09;
      chk("e9_set", 1, 8'h99);
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int e = 1; e <= 9; e++) step();
      rst = 1'b1;
      chk("busy_e10", 0, 8'h01);
      step();
      rst = 1'b0;
      for (int e = 0; e < 16; e++) begin
         chk("busy_rst_mid", 0, 8'h01);
         step();
      end
      chk("busy_rst_done", 0, 8'h00);
      chk("e9_cleared", 1, 8'h00);
      step();
      step();

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0",
                  sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
